bus_arbiter: RTL and testbench

- Arbitrates the shared external memory bus (o_addr/o_dat/o_we/o_cs/i_ack) between three masters:
  - video fetch (read-only, highest priority)
  - UART debug master
  - Z80 CPU (lowest priority)
- Replaces ad-hoc per-cycle master selection with a grant-holding FSM:
  - a granted master keeps the bus until its transaction is acknowledged, aborted or timed out;
  - a starvation guard ensures the CPU is eventually served;
  - generates CPU wait_n.

---
 rtl/bus_arbiter_if.sv | 40 ++++
 rtl/bus_arbiter.sv | 111 +++++++++++
 tb/tb_bus_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - Request/ack and external memory bus signals of the three-master arbiter.
interface bus_arbiter_if;
   logic        i_vga_cs;
   logic [15:0] i_vga_addr;
   logic        o_vga_ack;
   logic        i_uart_cs;
   logic        i_uart_we;
   logic [15:0] i_uart_addr;
   logic [7:0]  i_uart_dat;
   logic        o_uart_ack;
   logic        i_cpu_cs;
   logic        i_cpu_we;
   logic [15:0] i_cpu_addr;
   logic [7:0]  i_cpu_dat;
   logic        o_cpu_ack;
   logic        o_cpu_wait_n;
   logic [15:0] o_addr;
   logic [7:0]  o_dat;
   logic        o_we;
   logic        o_cs;
   logic        i_ack;
   logic        o_timeout;
   logic [1:0]  o_grant;

   // master: the arbiter, which drives the shared memory bus
   modport master (
      input  i_vga_cs, i_vga_addr, i_uart_cs, i_uart_we, i_uart_addr, i_uart_dat,
      input  i_cpu_cs, i_cpu_we, i_cpu_addr, i_cpu_dat, i_ack,
      output o_vga_ack, o_uart_ack, o_cpu_ack, o_cpu_wait_n,
      output o_addr, o_dat, o_we, o_cs, o_timeout, o_grant
   );

   // slave: the requesting masters plus the memory slave around the arbiter
   modport slave (
      output i_vga_cs, i_vga_addr, i_uart_cs, i_uart_we, i_uart_addr, i_uart_dat,
      output i_cpu_cs, i_cpu_we, i_cpu_addr, i_cpu_dat, i_ack,
      input  o_vga_ack, o_uart_ack, o_cpu_ack, o_cpu_wait_n,
      input  o_addr, o_dat, o_we, o_cs, o_timeout, o_grant
   );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - Grant-holding arbiter for video, UART and Z80 masters on the external memory bus.
module bus_arbiter #(
   parameter int unsigned TIMEOUT      = 255,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic          i_clk,
   input  logic          i_reset,
   bus_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t      state, state_nx;
   logic [1:0]  grant, grant_nx;
   logic [3:0]  starve_cnt, starve_nx;
   logic [15:0] to_cnt, to_nx;

   logic        own_cs;
   logic        own_we;
   logic [15:0] own_addr;
   logic [7:0]  own_dat;
   logic        own_ack;
   logic        timeout;

   // grant is non-zero only while in GRANT, so the mux alone blanks the bus elsewhere
   always_comb begin
      own_cs   = 1'b0;
      own_we   = 1'b0;
      own_addr = 16'd0;
      own_dat  = 8'd0;
      case (grant)
         2'd1: begin
            own_cs   = bus.i_vga_cs;
            own_addr = bus.i_vga_addr;
         end
         2'd2: begin
            own_cs   = bus.i_uart_cs;
            own_we   = bus.i_uart_we;
            own_addr = bus.i_uart_addr;
            own_dat  = bus.i_uart_dat;
         end
         2'd3: begin
            own_cs   = bus.i_cpu_cs;
            own_we   = bus.i_cpu_we;
            own_addr = bus.i_cpu_addr;
            own_dat  = bus.i_cpu_dat;
         end
         default: ;
      endcase
   end

   assign timeout = (state == GRANT) && own_cs && !bus.i_ack && (to_cnt == 16'(TIMEOUT - 1));
   assign own_ack = (state == GRANT) && own_cs && (bus.i_ack || timeout);

   always_comb begin
      state_nx  = state;
      grant_nx  = grant;
      starve_nx = starve_cnt;
      to_nx     = to_cnt;
      case (state)
         IDLE: begin
            to_nx = 16'd0;
            if (bus.i_cpu_cs && (starve_cnt >= 4'(STARVE_LIMIT))) grant_nx = 2'd3;
            else if (bus.i_vga_cs)                                 grant_nx = 2'd1;
            else if (bus.i_uart_cs)                                grant_nx = 2'd2;
            else if (bus.i_cpu_cs)                                 grant_nx = 2'd3;
            // a raised CPU request always produces some winner, so not-3 means the CPU lost
            if (!bus.i_cpu_cs || (grant_nx == 2'd3)) starve_nx = 4'd0;
            else if (starve_cnt != 4'd15)            starve_nx = starve_cnt + 4'd1;
            if (grant_nx != 2'd0) state_nx = GRANT;
         end
         GRANT: begin
            to_nx = to_cnt + 16'd1;
            if (!own_cs || bus.i_ack || timeout) begin
               state_nx = RELEASE;
               grant_nx = 2'd0;
            end
         end
         RELEASE: state_nx = IDLE;
         default: begin
            state_nx = IDLE;
            grant_nx = 2'd0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= IDLE;
         grant      <= 2'd0;
         starve_cnt <= 4'd0;
         to_cnt     <= 16'd0;
      end else begin
         state      <= state_nx;
         grant      <= grant_nx;
         starve_cnt <= starve_nx;
         to_cnt     <= to_nx;
      end
   end

   assign bus.o_grant      = grant;
   assign bus.o_cs         = own_cs;
   assign bus.o_we         = own_we;
   assign bus.o_addr       = own_addr;
   assign bus.o_dat        = own_dat;
   assign bus.o_timeout    = timeout;
   assign bus.o_vga_ack    = own_ack && (grant == 2'd1);
   assign bus.o_uart_ack   = own_ack && (grant == 2'd2);
   assign bus.o_cpu_ack    = own_ack && (grant == 2'd3);
   assign bus.o_cpu_wait_n = !(bus.i_cpu_cs &&
                               !((grant == 2'd3) && (state == GRANT) && bus.i_ack));
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - Randomized bench for bus_arbiter against a transaction-level reference model.
module tb_bus_arbiter;
   localparam int TIMEOUT      = 16;
   localparam int STARVE_LIMIT = 4;
   localparam int NPH          = 6;

   logic clk;
   logic reset;
   bus_arbiter_if bus ();

   bus_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // master agents, indexed 1 vga, 2 uart, 3 cpu
   bit          req [4];
   logic [15:0] adr [4];
   logic        wr  [4];
   logic [7:0]  dat [4];
   bit          ack;

   // reference model: who owns the bus, how long it has held it, and CPU losses
   int  m_owner;
   int  m_age;
   bit  m_gap;
   int  m_lost;

   // phase knobs: cycles, p_vga, p_uart, p_cpu, p_abort, p_ack, p_reset (percent)
   int ph [NPH][7] = '{
      '{300,  30,  30,  30,  3, 50, 1},
      '{200, 100,   0, 100,  0, 60, 0},
      '{150,   0,  80,   0,  0,  0, 0},
      '{300,  60,  60,  60,  5, 30, 2},
      '{200,  20,  20,  90, 10, 70, 1},
      '{150, 100, 100, 100,  0,  0, 3}
   };

   int          own, win;
   bit          e_cs, e_we, e_to, e_ack, e_wait, to_hit;
   logic [15:0] e_addr;
   logic [7:0]  e_dat;

   initial begin
      for (int m = 0; m < 4; m++) begin
         req[m] = 0; adr[m] = '0; wr[m] = 0; dat[m] = '0;
      end
      ack   = 0;
      reset = 1'b1;
      bus.i_vga_cs = 0;  bus.i_vga_addr = '0;
      bus.i_uart_cs = 0; bus.i_uart_we = 0; bus.i_uart_addr = '0; bus.i_uart_dat = '0;
      bus.i_cpu_cs = 0;  bus.i_cpu_we = 0;  bus.i_cpu_addr = '0;  bus.i_cpu_dat = '0;
      bus.i_ack = 0;
      repeat (2) @(posedge clk);
      #1;
      m_owner = 0; m_age = 0; m_gap = 0; m_lost = 0;

      for (int p = 0; p < NPH; p++) begin
         for (int c = 0; c < ph[p][0]; c++) begin
            for (int m = 1; m < 4; m++) begin
               if (req[m] && m != 1 && $urandom_range(99) < ph[p][4]) req[m] = 0;
               else if (!req[m] && $urandom_range(99) < ph[p][m]) begin
                  req[m] = 1;
                  adr[m] = 16'($urandom);
                  wr[m]  = (m == 1) ? 1'b0 : 1'($urandom);
                  dat[m] = 8'($urandom);
               end
            end
            ack   = ($urandom_range(99) < ph[p][5]);
            reset = (c > 0) && ($urandom_range(99) < ph[p][6]);
            bus.i_vga_cs  = req[1]; bus.i_vga_addr  = adr[1];
            bus.i_uart_cs = req[2]; bus.i_uart_we   = wr[2];
            bus.i_uart_addr = adr[2]; bus.i_uart_dat = dat[2];
            bus.i_cpu_cs  = req[3]; bus.i_cpu_we    = wr[3];
            bus.i_cpu_addr = adr[3];  bus.i_cpu_dat  = dat[3];
            bus.i_ack     = ack;
            #4;

            own    = m_owner;
            e_cs   = (own != 0) && req[own];
            e_addr = (own != 0) ? adr[own] : 16'd0;
            e_we   = (own >= 2) ? wr[own]  : 1'b0;
            e_dat  = (own >= 2) ? dat[own] : 8'd0;
            to_hit = (own != 0) && (m_age == TIMEOUT - 1);
            e_to   = e_cs && !ack && to_hit;
            e_ack  = e_cs && (ack || to_hit);
            e_wait = !(req[3] && !(own == 3 && ack));

            check_val("grant",    32'(bus.o_grant),      32'(own));
            check_val("cs",       32'(bus.o_cs),         32'(e_cs));
            check_val("addr",     32'(bus.o_addr),       32'(e_addr));
            check_val("we",       32'(bus.o_we),         32'(e_we));
            check_val("dat",      32'(bus.o_dat),        32'(e_dat));
            check_val("timeout",  32'(bus.o_timeout),    32'(e_to));
            check_val("vga_ack",  32'(bus.o_vga_ack),    32'(e_ack && own == 1));
            check_val("uart_ack", 32'(bus.o_uart_ack),   32'(e_ack && own == 2));
            check_val("cpu_ack",  32'(bus.o_cpu_ack),    32'(e_ack && own == 3));
            check_val("wait_n",   32'(bus.o_cpu_wait_n), 32'(e_wait));

            if (e_ack) req[own] = 0;
            if (reset) begin
               m_owner = 0; m_age = 0; m_gap = 0; m_lost = 0;
            end else if (m_gap) begin
               m_gap = 0;
            end else if (m_owner == 0) begin
               win = 0;
               if (bus.i_cpu_cs && m_lost >= STARVE_LIMIT) win = 3;
               else if (bus.i_vga_cs)  win = 1;
               else if (bus.i_uart_cs) win = 2;
               else if (bus.i_cpu_cs)  win = 3;
               if (!bus.i_cpu_cs || win == 3) m_lost = 0;
               else m_lost = (m_lost < 15) ? m_lost + 1 : 15;
               m_owner = win;
               m_age   = 0;
            end else if (!e_cs || e_ack) begin
               m_owner = 0;
               m_gap   = 1;
            end else begin
               m_age++;
            end

            @(posedge clk);
            #1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
